// File: rtl/load_buffer.sv
// Load buffer: parks loads until all bytes are present (forwarded, hit or refilled),
// then writes them back on the CDB with funct3 width/sign handling.
module load_buffer #(
  parameter int LB_DEPTH   = 4,
  parameter int MSHR_IDX_W = 3,
  parameter int BR_MASK_W  = 4,
  parameter int PREG_W     = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  lb_in_valid,
  input  logic [BR_MASK_W-1:0]  lb_in_bm,
  input  logic [PREG_W-1:0]     lb_in_dest,
  input  logic [31:0]           lb_in_addr,
  input  logic [2:0]            lb_in_func,
  input  logic [31:0]           lb_in_result,
  input  logic [3:0]            lb_in_byte_mask,
  input  logic [MSHR_IDX_W-1:0] lb_in_mshr_idx,
  output logic                  lb_full,
  input  logic                  refill_valid,
  input  logic [MSHR_IDX_W-1:0] refill_mshr_idx,
  input  logic [63:0]           refill_data,
  output logic                  wb_valid,
  output logic [PREG_W-1:0]     wb_dest,
  output logic [31:0]           wb_data,
  input  logic                  wb_ready,
  input  logic [BR_MASK_W-1:0]  b_mm_resolve,
  input  logic                  b_mm_mispred
);

  localparam int IDX_W = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int CNT_W = $clog2(LB_DEPTH + 1);

  typedef enum logic [1:0] {FREE = 2'd0, WAIT = 2'd1, READY = 2'd2} state_t;

  state_t                state_q  [LB_DEPTH];
  state_t                state_d  [LB_DEPTH];
  logic [BR_MASK_W-1:0]  bm_q     [LB_DEPTH];
  logic [BR_MASK_W-1:0]  bm_d     [LB_DEPTH];
  logic [PREG_W-1:0]     dest_q   [LB_DEPTH];
  logic [PREG_W-1:0]     dest_d   [LB_DEPTH];
  logic [2:0]            addr_q   [LB_DEPTH];
  logic [2:0]            addr_d   [LB_DEPTH];
  logic [2:0]            func_q   [LB_DEPTH];
  logic [2:0]            func_d   [LB_DEPTH];
  logic [31:0]           result_q [LB_DEPTH];
  logic [31:0]           result_d [LB_DEPTH];
  logic [3:0]            mask_q   [LB_DEPTH];
  logic [3:0]            mask_d   [LB_DEPTH];
  logic [MSHR_IDX_W-1:0] mshr_q   [LB_DEPTH];
  logic [MSHR_IDX_W-1:0] mshr_d   [LB_DEPTH];

  logic                  lb_full_q;
  logic                  lb_full_d;
  logic                  held_vld_q;
  logic                  held_vld_d;
  logic [IDX_W-1:0]      held_idx_q;
  logic [IDX_W-1:0]      held_idx_d;

  logic [LB_DEPTH-1:0]   kill;
  logic [LB_DEPTH-1:0]   live;
  logic                  any_live;
  logic [IDX_W-1:0]      sel;
  logic                  grant;
  logic                  in_kill;
  logic                  have_free;
  logic [IDX_W-1:0]      alloc_idx;
  logic                  enq;
  logic                  in_hit;
  logic [31:0]           in_result;
  logic [3:0]            in_mask;
  logic [CNT_W-1:0]      occ;

  logic unused_addr_hi;
  assign unused_addr_hi = ^lb_in_addr[31:3];

  function automatic logic [31:0] merge_refill(input logic [31:0] cur, input logic [3:0] mask,
                                               input logic [63:0] line, input logic lane);
    logic [31:0] w;
    logic [31:0] r;
    w = lane ? line[63:32] : line[31:0];
    r = cur;
    for (int b = 0; b < 4; b++)
      if (mask[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] func, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0]        sh;
    logic signed [7:0]  s8;
    logic signed [15:0] s16;
    logic signed [31:0] r;
    sh  = word >> {off, 3'b000};
    s8  = $signed(sh[7:0]);
    s16 = $signed(sh[15:0]);
    case (func)
      3'b000:  r = 32'(s8);
      3'b001:  r = 32'(s16);
      3'b100:  r = $signed({24'b0, sh[7:0]});
      3'b101:  r = $signed({16'b0, sh[15:0]});
      default: r = $signed(sh);
    endcase
    return r;
  endfunction

  // Squash detection and writeback selection
  always_comb begin
    in_kill  = b_mm_mispred && (|(lb_in_bm & b_mm_resolve));
    kill     = '0;
    live     = '0;
    any_live = 1'b0;
    sel      = '0;
    for (int i = 0; i < LB_DEPTH; i++) begin
      kill[i] = b_mm_mispred && (state_q[i] != FREE) && (|(bm_q[i] & b_mm_resolve));
      live[i] = (state_q[i] == READY) && !kill[i];
    end
    for (int i = LB_DEPTH - 1; i >= 0; i--) begin
      if (live[i]) begin
        sel      = IDX_W'(i);
        any_live = 1'b1;
      end
    end
    // A refused writeback keeps its slot on the bus until granted or squashed.
    if (held_vld_q && live[held_idx_q]) sel = held_idx_q;
  end

  assign grant    = any_live && wb_ready;
  assign wb_valid = any_live;
  assign wb_dest  = any_live ? dest_q[sel] : '0;
  assign wb_data  = any_live ? load_extend(func_q[sel], addr_q[sel][1:0], result_q[sel]) : '0;
  assign lb_full  = lb_full_q;

  // Allocation and same-cycle refill bypass for the incoming load
  always_comb begin
    have_free = 1'b0;
    alloc_idx = '0;
    for (int i = LB_DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == FREE) begin
        have_free = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
    enq       = lb_in_valid && !lb_full_q && !in_kill && have_free;
    in_hit    = refill_valid && (lb_in_mshr_idx == refill_mshr_idx);
    in_result = in_hit ? merge_refill(lb_in_result, lb_in_byte_mask, refill_data, lb_in_addr[2])
                       : lb_in_result;
    in_mask   = in_hit ? 4'b0000 : lb_in_byte_mask;
  end

  // Entry next-state: squash, then refill / writeback, then enqueue into a free slot
  always_comb begin
    state_d  = state_q;
    bm_d     = bm_q;
    dest_d   = dest_q;
    addr_d   = addr_q;
    func_d   = func_q;
    result_d = result_q;
    mask_d   = mask_q;
    mshr_d   = mshr_q;
    for (int i = 0; i < LB_DEPTH; i++) begin
      if (state_q[i] != FREE) begin
        if (kill[i]) begin
          state_d[i] = FREE;
        end else begin
          bm_d[i] = bm_q[i] & ~b_mm_resolve;
          if (state_q[i] == WAIT && refill_valid && mshr_q[i] == refill_mshr_idx) begin
            result_d[i] = merge_refill(result_q[i], mask_q[i], refill_data, addr_q[i][2]);
            mask_d[i]   = 4'b0000;
            state_d[i]  = READY;
          end else if (grant && sel == IDX_W'(i)) begin
            state_d[i] = FREE;
          end
        end
      end else if (enq && alloc_idx == IDX_W'(i)) begin
        state_d[i]  = (in_mask == 4'b0000) ? READY : WAIT;
        bm_d[i]     = lb_in_bm & ~b_mm_resolve;
        dest_d[i]   = lb_in_dest;
        addr_d[i]   = lb_in_addr[2:0];
        func_d[i]   = lb_in_func;
        result_d[i] = in_result;
        mask_d[i]   = in_mask;
        mshr_d[i]   = lb_in_mshr_idx;
      end
    end
    occ = '0;
    for (int i = 0; i < LB_DEPTH; i++)
      if (state_d[i] != FREE) occ = occ + CNT_W'(1);
    lb_full_d  = (occ == CNT_W'(LB_DEPTH));
    held_vld_d = any_live && !wb_ready;
    held_idx_d = sel;
  end

  // Control state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < LB_DEPTH; i++) state_q[i] <= FREE;
      lb_full_q  <= 1'b0;
      held_vld_q <= 1'b0;
      held_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lb_full_q  <= lb_full_d;
      held_vld_q <= held_vld_d;
      held_idx_q <= held_idx_d;
    end
  end

  // Entry payload register
  always_ff @(posedge clock) begin
    bm_q     <= bm_d;
    dest_q   <= dest_d;
    addr_q   <= addr_d;
    func_q   <= func_d;
    result_q <= result_d;
    mask_q   <= mask_d;
    mshr_q   <= mshr_d;
  end

  always_ff @(posedge clock) begin
    if (reset)
      assert (!(lb_in_valid && lb_full_q))
        else $error("load_buffer: enqueue while full, load dropped");
  end

endmodule

// File: tb/tb_load_buffer.sv
// Directed bench for load_buffer: writebacks are predicted into a scoreboard queue
// when stimulus is applied and popped when the CDB handshake completes.
module tb_load_buffer;

  logic        clock;
  logic        reset;
  logic        lb_in_valid;
  logic [3:0]  lb_in_bm;
  logic [5:0]  lb_in_dest;
  logic [31:0] lb_in_addr;
  logic [2:0]  lb_in_func;
  logic [31:0] lb_in_result;
  logic [3:0]  lb_in_byte_mask;
  logic [2:0]  lb_in_mshr_idx;
  logic        lb_full;
  logic        refill_valid;
  logic [2:0]  refill_mshr_idx;
  logic [63:0] refill_data;
  logic        wb_valid;
  logic [5:0]  wb_dest;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic [3:0]  b_mm_resolve;
  logic        b_mm_mispred;

  typedef struct packed {
    logic [5:0]  dest;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  load_buffer dut (
    .clock(clock), .reset(reset),
    .lb_in_valid(lb_in_valid), .lb_in_bm(lb_in_bm), .lb_in_dest(lb_in_dest),
    .lb_in_addr(lb_in_addr), .lb_in_func(lb_in_func), .lb_in_result(lb_in_result),
    .lb_in_byte_mask(lb_in_byte_mask), .lb_in_mshr_idx(lb_in_mshr_idx), .lb_full(lb_full),
    .refill_valid(refill_valid), .refill_mshr_idx(refill_mshr_idx), .refill_data(refill_data),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .wb_ready(wb_ready),
    .b_mm_resolve(b_mm_resolve), .b_mm_mispred(b_mm_mispred)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  task automatic clr();
    lb_in_valid     = 1'b0;
    lb_in_bm        = '0;
    lb_in_dest      = '0;
    lb_in_addr      = '0;
    lb_in_func      = '0;
    lb_in_result    = '0;
    lb_in_byte_mask = '0;
    lb_in_mshr_idx  = '0;
    refill_valid    = 1'b0;
    refill_mshr_idx = '0;
    refill_data     = '0;
    b_mm_resolve    = '0;
    b_mm_mispred    = 1'b0;
  endtask

  task automatic enq(input logic [3:0] bm, input logic [5:0] dest, input logic [31:0] addr,
                     input logic [2:0] func, input logic [31:0] result, input logic [3:0] mask,
                     input logic [2:0] mshr);
    lb_in_valid     = 1'b1;
    lb_in_bm        = bm;
    lb_in_dest      = dest;
    lb_in_addr      = addr;
    lb_in_func      = func;
    lb_in_result    = result;
    lb_in_byte_mask = mask;
    lb_in_mshr_idx  = mshr;
  endtask

  task automatic refill(input logic [2:0] idx, input logic [63:0] data);
    refill_valid    = 1'b1;
    refill_mshr_idx = idx;
    refill_data     = data;
  endtask

  task automatic push(input logic [5:0] dest, input logic [31:0] data);
    exp_t e;
    e.dest = dest;
    e.data = data;
    sb.push_back(e);
  endtask

  // Scoreboard: every completed CDB handshake must match the oldest prediction
  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b1 && wb_valid === 1'b1 && wb_ready === 1'b1) begin
      checks++;
      assert (sb.size() != 0)
        else begin
          errors++;
          $error("FAIL wb_unexpected observed dest=%0d data=%h expected=no writeback", wb_dest, wb_data);
        end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_dest", 32'(wb_dest), 32'(e.dest));
        chk("wb_data", wb_data, e.data);
      end
    end
  end

  initial begin
    reset    = 1'b0;
    wb_ready = 1'b0;
    clr();
    tick();
    tick();
    at_neg();
    chk("rst_full", 32'(lb_full), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_dest", 32'(wb_dest), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);

    // LW hit goes straight to READY
    tick(); clr(); reset = 1'b1; wb_ready = 1'b1;
    enq(4'b0000, 6'd5, 32'h1004, 3'b010, 32'hDEADBEEF, 4'b0000, 3'd0);
    push(6'd5, 32'hDEADBEEF);
    tick(); clr(); at_neg();
    chk("t1_wb_valid", 32'(wb_valid), 32'd1);
    tick(); clr(); at_neg();
    chk("t1_freed", 32'(wb_valid), 32'd0);

    // LB / LBU missing lane 3, filled by refill
    tick(); clr();
    enq(4'b0000, 6'd7, 32'h1003, 3'b000, 32'h0, 4'b1000, 3'd2);
    tick(); clr();
    refill(3'd2, 64'h11223344_80ABCDEF);
    push(6'd7, 32'hFFFFFF80);
    at_neg();
    chk("t2_wait", 32'(wb_valid), 32'd0);
    tick(); clr(); at_neg();
    chk("t2_lb_valid", 32'(wb_valid), 32'd1);
    tick(); clr();
    enq(4'b0000, 6'd8, 32'h1003, 3'b100, 32'h0, 4'b1000, 3'd2);
    tick(); clr();
    refill(3'd2, 64'h11223344_80ABCDEF);
    push(6'd8, 32'h00000080);
    at_neg();
    chk("t2u_wait", 32'(wb_valid), 32'd0);
    tick(); clr(); at_neg();
    chk("t2u_valid", 32'(wb_valid), 32'd1);

    // Fill all four entries waiting on MSHR 1
    tick(); clr(); wb_ready = 1'b0;
    enq(4'b0000, 6'd10, 32'h2000, 3'b010, 32'h0, 4'b1111, 3'd1);
    tick(); clr();
    enq(4'b0000, 6'd11, 32'h2000, 3'b010, 32'h0, 4'b1111, 3'd1);
    tick(); clr();
    enq(4'b0000, 6'd12, 32'h2000, 3'b010, 32'h0, 4'b1111, 3'd1);
    tick(); clr(); at_neg();
    chk("t3_not_full", 32'(lb_full), 32'd0);
    enq(4'b0000, 6'd13, 32'h2000, 3'b010, 32'h0, 4'b1111, 3'd1);
    tick(); clr(); at_neg();
    chk("t3_full", 32'(lb_full), 32'd1);
    chk("t3_wait_idle", 32'(wb_valid), 32'd0);
    tick(); clr(); at_neg();
    chk("t3_full_hold", 32'(lb_full), 32'd1);
    tick(); clr();
    refill(3'd1, 64'hFFFFFFFF_12345678);
    push(6'd10, 32'h12345678);
    push(6'd11, 32'h12345678);
    push(6'd12, 32'h12345678);
    push(6'd13, 32'h12345678);
    tick(); clr(); at_neg();
    chk("t3_ready", 32'(wb_valid), 32'd1);
    chk("t3_first_dest", 32'(wb_dest), 32'd10);
    chk("t3_still_full", 32'(lb_full), 32'd1);
    tick(); clr(); wb_ready = 1'b1; at_neg();
    tick(); clr(); at_neg();
    chk("t3_full_drop", 32'(lb_full), 32'd0);
    tick(); clr(); at_neg();
    tick(); clr(); at_neg();
    tick(); clr(); wb_ready = 1'b0;
    enq(4'b0000, 6'd21, 32'h3000, 3'b010, 32'h11223300, 4'b0001, 3'd4);
    at_neg();
    chk("t3_drained", 32'(wb_valid), 32'd0);
    chk("t3_empty", 32'(lb_full), 32'd0);

    // Held writeback stays stable while a lower entry becomes READY
    tick(); clr();
    enq(4'b0000, 6'd20, 32'h3002, 3'b001, 32'h80010000, 4'b0000, 3'd0);
    tick(); clr(); at_neg();
    chk("t4_hold1_dest", 32'(wb_dest), 32'd20);
    chk("t4_hold1_data", wb_data, 32'hFFFF8001);
    tick(); clr();
    refill(3'd4, 64'h00000000_000000AA);
    at_neg();
    chk("t4_hold2_valid", 32'(wb_valid), 32'd1);
    chk("t4_hold2_dest", 32'(wb_dest), 32'd20);
    tick(); clr(); at_neg();
    chk("t4_hold3_dest", 32'(wb_dest), 32'd20);
    chk("t4_hold3_data", wb_data, 32'hFFFF8001);
    tick(); clr(); wb_ready = 1'b1;
    push(6'd20, 32'hFFFF8001);
    push(6'd21, 32'h112233AA);
    at_neg();
    tick(); clr(); at_neg();
    tick(); clr(); wb_ready = 1'b0;
    enq(4'b0010, 6'd30, 32'h4000, 3'b010, 32'hAAAA0001, 4'b0000, 3'd0);
    at_neg();
    chk("t4_done", 32'(wb_valid), 32'd0);

    // Branch squash and branch-tag clearing
    tick(); clr();
    enq(4'b0100, 6'd31, 32'h4004, 3'b010, 32'hBBBB0002, 4'b0000, 3'd0);
    at_neg();
    chk("t5_a_dest", 32'(wb_dest), 32'd30);
    tick(); clr();
    b_mm_resolve = 4'b0010; b_mm_mispred = 1'b1;
    at_neg();
    chk("t5_squash_valid", 32'(wb_valid), 32'd1);
    chk("t5_squash_dest", 32'(wb_dest), 32'd31);
    tick(); clr();
    b_mm_resolve = 4'b0100; b_mm_mispred = 1'b0;
    at_neg();
    chk("t5_correct_dest", 32'(wb_dest), 32'd31);
    tick(); clr();
    b_mm_resolve = 4'b0100; b_mm_mispred = 1'b1;
    at_neg();
    chk("t5_bm_cleared", 32'(wb_valid), 32'd1);
    tick(); clr();
    b_mm_resolve = 4'b1000; b_mm_mispred = 1'b1;
    enq(4'b1000, 6'd32, 32'h4008, 3'b010, 32'hCCCC0003, 4'b0000, 3'd0);
    wb_ready = 1'b1;
    push(6'd31, 32'hBBBB0002);
    at_neg();
    tick(); clr(); at_neg();
    chk("t5_in_squashed", 32'(wb_valid), 32'd0);

    // Enqueue with same-cycle refill bypass, upper word lane
    tick(); clr();
    enq(4'b0000, 6'd40, 32'h5006, 3'b101, 32'h00001234, 4'b1100, 3'd3);
    refill(3'd3, 64'hBEEF0000_00000000);
    push(6'd40, 32'h0000BEEF);
    at_neg();
    tick(); clr(); at_neg();
    chk("t6_bypass_valid", 32'(wb_valid), 32'd1);

    // Mid-operation reset drops WAIT entries and ignores a refill
    tick(); clr();
    enq(4'b0000, 6'd41, 32'h6000, 3'b010, 32'h0, 4'b1111, 3'd5);
    tick(); clr();
    enq(4'b0000, 6'd42, 32'h6004, 3'b010, 32'h0, 4'b1111, 3'd5);
    tick(); clr(); at_neg();
    chk("t6_wait_idle", 32'(wb_valid), 32'd0);
    tick(); clr(); reset = 1'b0;
    refill(3'd5, 64'h55555555_66666666);
    at_neg();
    tick(); clr(); reset = 1'b1; at_neg();
    chk("t6_rst_valid", 32'(wb_valid), 32'd0);
    chk("t6_rst_full", 32'(lb_full), 32'd0);
    chk("t6_rst_data", wb_data, 32'd0);
    tick(); clr();
    refill(3'd5, 64'h55555555_66666666);
    at_neg();
    tick(); clr(); at_neg();
    chk("t6_dropped", 32'(wb_valid), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
